// File: rtl/e203_exu_fpu_fmac_add_pkg.sv
// Shared types and constants for the FMAC add stage: FSM encoding, exponent
// limits and the internal mantissa width (hidden + 23 fraction + G/R/S).
package e203_exu_fpu_fmac_add_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_UNPACK  = 4'd1,
    ST_SPECIAL = 4'd2,
    ST_ALIGN   = 4'd3,
    ST_ADD     = 4'd4,
    ST_NORM    = 4'd5,
    ST_ROUND   = 4'd6,
    ST_PACK    = 4'd7,
    ST_OUT     = 4'd8
  } state_t;

  localparam int               MANT_W   = 27;
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MIN  = -10'sd126;

  // Subnormal exponent field 0 is treated as the minimum exponent.
  function automatic logic signed [9:0] unbias(input logic [7:0] f);
    return (f == 8'd0) ? EXP_MIN : ($signed({2'b00, f}) - EXP_BIAS);
  endfunction

endpackage

// File: rtl/e203_exu_fpu_rshift_sticky.sv
// Combinational 27-bit right shifter; bits shifted out are ORed into bit 0.
// Amounts of 27 or more leave only the sticky bit.
module e203_exu_fpu_rshift_sticky
  import e203_exu_fpu_fmac_add_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  input  logic [4:0]        amt,
  output logic [MANT_W-1:0] dout
);

  logic [MANT_W-1:0] lost;

  always_comb begin
    lost = '0;
    dout = '0;
    if (amt >= 5'd27) begin
      dout = {{(MANT_W-1){1'b0}}, |din};
    end else begin
      lost = din & ~({MANT_W{1'b1}} << amt);
      dout = (din >> amt) | {{(MANT_W-1){1'b0}}, |lost};
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fmac_add.sv
// FMAC second stage: multi-cycle single-precision adder (RNE, subnormals)
// with valid/ready handshakes on the operand and result sides.
module e203_exu_fpu_fmac_add
  import e203_exu_fpu_fmac_add_pkg::*;
#(
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fmac_add_i_valid,
  output logic        fmac_add_i_ready,
  input  logic [31:0] fmac_i_op_a,
  input  logic [31:0] fmac_i_op_b,
  input  logic        fmac_i_sub,
  output logic        fmac_add_o_valid,
  input  logic        fmac_add_o_ready,
  output logic [31:0] fmac_add_o_wbck_wdat
);

  state_t                   state, state_nxt;
  logic [31:0]              raw_a, raw_b;
  logic                     sign_a, sign_b, res_sign;
  logic signed [9:0]        exp_a, exp_b, res_exp;
  logic [MANT_W-1:0]        man_a, man_b, sum;

  function automatic logic [24:0] round_rne(input logic [MANT_W-1:0] m);
    logic inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + {24'd0, inc};
  endfunction

  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic hid, input logic [22:0] frac);
    logic signed [9:0] biased;
    biased = e + EXP_BIAS;
    if (e > EXP_BIAS)  return {s, 8'hFF, 23'd0};
    else if (!hid)     return {s, 8'h00, frac};
    else               return {s, biased[7:0], frac};
  endfunction

  // Special-case decode on the captured raw words
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, special_hit;
  logic [31:0] special_res;
  assign a_nan  = (&raw_a[30:23]) & (|raw_a[22:0]);
  assign b_nan  = (&raw_b[30:23]) & (|raw_b[22:0]);
  assign a_inf  = (&raw_a[30:23]) & ~(|raw_a[22:0]);
  assign b_inf  = (&raw_b[30:23]) & ~(|raw_b[22:0]);
  assign a_zero = ~(|raw_a[30:0]);
  assign b_zero = ~(|raw_b[30:0]);
  assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    special_res = raw_a;
    if (a_nan | b_nan)                           special_res = NAN_VAL;
    else if (a_inf & b_inf & (raw_a[31] != raw_b[31])) special_res = NAN_VAL;
    else if (a_inf)                              special_res = raw_a;
    else if (b_inf)                              special_res = raw_b;
    else if (a_zero & b_zero)                    special_res = {raw_a[31] & raw_b[31], 31'd0};
    else if (a_zero)                             special_res = raw_b;
    else                                         special_res = raw_a;
  end

  // Alignment of the smaller-exponent operand
  logic                    a_ge;
  logic signed [9:0]       exp_diff;
  logic [4:0]              sh_amt;
  logic [MANT_W-1:0]       sh_in, sh_out;
  assign a_ge     = (exp_a >= exp_b);
  assign exp_diff = a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
  assign sh_amt   = (exp_diff > 10'sd26) ? 5'd27 : exp_diff[4:0];
  assign sh_in    = a_ge ? man_b : man_a;

  e203_exu_fpu_rshift_sticky u_rshift (
    .din  (sh_in),
    .amt  (sh_amt),
    .dout (sh_out)
  );

  // Magnitude add/subtract; operands are already aligned to res_exp
  logic [MANT_W:0] add_sum;
  logic            add_sign, add_zero, norm_shift;
  logic [24:0]     rnd;
  always_comb begin
    if (sign_a == sign_b) begin
      add_sum  = {1'b0, man_a} + {1'b0, man_b};
      add_sign = sign_a;
    end else if (man_a >= man_b) begin
      add_sum  = {1'b0, man_a} - {1'b0, man_b};
      add_sign = sign_a;
    end else begin
      add_sum  = {1'b0, man_b} - {1'b0, man_a};
      add_sign = sign_b;
    end
  end
  assign add_zero   = (add_sum == '0);
  assign norm_shift = ~sum[MANT_W-1] && (res_exp > EXP_MIN);
  assign rnd        = round_rne(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (fmac_add_i_valid) state_nxt = ST_UNPACK;
      ST_UNPACK:  state_nxt = ST_SPECIAL;
      ST_SPECIAL: state_nxt = special_hit ? ST_OUT : ST_ALIGN;
      ST_ALIGN:   state_nxt = ST_ADD;
      ST_ADD:     state_nxt = add_zero ? ST_OUT : ST_NORM;
      ST_NORM:    if (!norm_shift) state_nxt = ST_ROUND;
      ST_ROUND:   state_nxt = ST_PACK;
      ST_PACK:    state_nxt = ST_OUT;
      ST_OUT:     if (fmac_add_o_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fmac_add_i_ready = (state == ST_IDLE);
    fmac_add_o_valid = (state == ST_OUT);
  end

  // Result word: cleared on reset, held while waiting in OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmac_add_o_wbck_wdat <= '0;
    end else begin
      case (state)
        ST_SPECIAL: if (special_hit) fmac_add_o_wbck_wdat <= special_res;
        ST_ADD:     if (add_zero)    fmac_add_o_wbck_wdat <= 32'd0;
        ST_PACK:    fmac_add_o_wbck_wdat <= pack(res_sign, res_exp, sum[26], sum[25:3]);
        default:    ;
      endcase
    end
  end

  // Datapath registers carry no reset; state alone decides their meaning
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        raw_a <= fmac_i_op_a;
        raw_b <= fmac_i_op_b ^ {fmac_i_sub, 31'd0};
      end
      ST_UNPACK: begin
        sign_a <= raw_a[31];
        sign_b <= raw_b[31];
        exp_a  <= unbias(raw_a[30:23]);
        exp_b  <= unbias(raw_b[30:23]);
        man_a  <= {|raw_a[30:23], raw_a[22:0], 3'b000};
        man_b  <= {|raw_b[30:23], raw_b[22:0], 3'b000};
      end
      ST_ALIGN: begin
        if (a_ge) begin
          man_b   <= sh_out;
          res_exp <= exp_a;
        end else begin
          man_a   <= sh_out;
          res_exp <= exp_b;
        end
      end
      ST_ADD: begin
        res_sign <= add_sign;
        if (add_sum[MANT_W]) begin
          sum     <= add_sum[MANT_W:1] | {{(MANT_W-1){1'b0}}, add_sum[0]};
          res_exp <= res_exp + 10'sd1;
        end else begin
          sum     <= add_sum[MANT_W-1:0];
        end
      end
      ST_NORM: begin
        if (norm_shift) begin
          sum     <= sum << 1;
          res_exp <= res_exp - 10'sd1;
        end
      end
      ST_ROUND: begin
        if (rnd[24]) begin
          sum     <= {24'h800000, 3'b000};
          res_exp <= res_exp + 10'sd1;
        end else begin
          sum     <= {rnd[23:0], 3'b000};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e203_exu_fpu_fmac_add.sv
// Scoreboard bench for the FMAC add stage: directed vectors, latency,
// backpressure and mid-operation reset.
module tb_e203_exu_fpu_fmac_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, sub, o_valid, o_ready;
  logic [31:0] op_a, op_b, wdat;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  e203_exu_fpu_fmac_add dut (
    .clk                  (clk),
    .rst                  (rst),
    .fmac_add_i_valid     (i_valid),
    .fmac_add_i_ready     (i_ready),
    .fmac_i_op_a          (op_a),
    .fmac_i_op_b          (op_b),
    .fmac_i_sub           (sub),
    .fmac_add_o_valid     (o_valid),
    .fmac_add_o_ready     (o_ready),
    .fmac_add_o_wbck_wdat (wdat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] res, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; i_valid = 1'b1;
    if (push) begin
      e.name = name; e.data = res; e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    while (!i_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({name, "_accept_timeout"}, {31'd0, i_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // Monitor: latency measured to the first o_valid, data checked at handshake
  initial begin
    bit   seen;
    int   first_lat;
    exp_t e;
    seen = 1'b0;
    first_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (o_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_lat = cyc - acc_cyc;
        end
        if (o_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%h expected=no_output", wdat);
          end else begin
            e = exp_q.pop_front();
            chk(e.name, wdat, e.data);
            if (e.lat >= 0) chk({e.name, "_latency"}, first_lat, e.lat);
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] hold;
    int          n;
    rst = 1'b1; i_valid = 1'b1; o_ready = 1'b1; sub = 1'b0;
    op_a = 32'h3F800000; op_b = 32'h40000000;
    repeat (3) @(negedge clk);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_i_ready", {31'd0, i_ready}, 32'd1);
    chk("post_rst_o_valid", {31'd0, o_valid}, 32'd0);

    issue("add_1_2",       32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 8, 1'b1);
    issue("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 8, 1'b1);
    issue("tie_up",        32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 8, 1'b1);
    issue("cancel",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5, 1'b1);
    issue("near_cancel",   32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, -1, 1'b1);
    issue("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3, 1'b1);
    issue("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3, 1'b1);
    issue("neg_zeros",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3, 1'b1);
    issue("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 8, 1'b1);
    issue("sub_tiny",      32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 8, 1'b1);
    issue("sub_to_norm",   32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 8, 1'b1);
    wait_done();

    // Backpressure: result must sit still until writeback takes it
    @(posedge clk); #1;
    o_ready = 1'b0;
    issue("bp_add", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 8, 1'b1);
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_o_valid_seen", {31'd0, o_valid}, 32'd1);
    hold = wdat;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wdat_stable", wdat, hold);
      chk("bp_i_ready_low", {31'd0, i_ready}, 32'd0);
      chk("bp_o_valid_high", {31'd0, o_valid}, 32'd1);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_single_xfer", {31'd0, o_valid}, 32'd0);
    chk("bp_i_ready_back", {31'd0, i_ready}, 32'd1);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Reset while the long normalisation is in progress
    issue("rst_mid", 32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, -1, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_wdat", wdat, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_i_ready", {31'd0, i_ready}, 32'd1);
    chk("mid_rst_o_valid_after", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_wdat_after", wdat, 32'd0);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_output", {31'd0, o_valid}, 32'd0);
    issue("after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 8, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
